// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Brief    : Packs a byte stream into 16-bit words through a 2-entry output
//            FIFO, with flush of a half-assembled word using a pad byte.
// Revision : 1.0 - initial release
// ============================================================================
module word_assembler #(
    parameter int         HI_FIRST = 1,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        CK,
    input  logic        RESET,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    input  logic        FLUSH,
    output logic        FLUSH_BUSY,
    output logic [15:0] WORD_OUT,
    output logic        WORD_VALID,
    input  logic        WORD_READY,
    output logic        LOAD,
    output logic        ODD
);

    typedef enum logic [0:0] {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } phase_t;

    phase_t      r_phase,      w_phase_nxt;
    logic [7:0]  r_hold,       w_hold_nxt;
    logic [1:0]  r_count,      w_count_nxt;
    logic        r_flush_pend, w_flush_pend_nxt;
    logic [15:0] r_ent0,       w_ent0_nxt;
    logic [15:0] r_ent1,       w_ent1_nxt;

    logic        w_byte_xfer;
    logic        w_pop;
    logic        w_push_word;
    logic        w_push_pad;
    logic        w_push;
    logic [15:0] w_word_data;
    logic [15:0] w_pad_data;
    logic [15:0] w_push_data;

    assign BYTE_READY = !RESET && !r_flush_pend &&
                        ((r_phase == S_EVEN) || (r_count != 2'd2));
    assign WORD_VALID = (r_count != 2'd0);
    assign WORD_OUT   = r_ent0;
    assign LOAD       = WORD_VALID && WORD_READY;
    assign FLUSH_BUSY = r_flush_pend;
    assign ODD        = (r_phase == S_ODD);

    assign w_byte_xfer = BYTE_VALID && BYTE_READY;
    assign w_pop       = LOAD;
    assign w_push_word = w_byte_xfer && (r_phase == S_ODD);
    // Pad push looks at the pre-pop count; BYTE_READY is low while pending,
    // so it can never collide with a data push.
    assign w_push_pad  = r_flush_pend && (r_count != 2'd2);
    assign w_push      = w_push_word || w_push_pad;

    assign w_word_data = (HI_FIRST != 0) ? {r_hold, BYTE_IN}  : {BYTE_IN, r_hold};
    assign w_pad_data  = (HI_FIRST != 0) ? {r_hold, PAD_BYTE} : {PAD_BYTE, r_hold};
    assign w_push_data = w_push_pad ? w_pad_data : w_word_data;

    always_comb begin
        w_phase_nxt      = r_phase;
        w_hold_nxt       = r_hold;
        w_flush_pend_nxt = r_flush_pend;
        w_count_nxt      = r_count;
        w_ent0_nxt       = r_ent0;
        w_ent1_nxt       = r_ent1;

        if (w_byte_xfer) begin
            if (r_phase == S_EVEN) begin
                w_phase_nxt = S_ODD;
                w_hold_nxt  = BYTE_IN;
            end else begin
                w_phase_nxt = S_EVEN;
            end
        end

        if (w_push_pad) begin
            w_phase_nxt      = S_EVEN;
            w_flush_pend_nxt = 1'b0;
        end else if (FLUSH && !r_flush_pend &&
                     (((r_phase == S_EVEN) &&  w_byte_xfer) ||
                      ((r_phase == S_ODD)  && !w_byte_xfer))) begin
            w_flush_pend_nxt = 1'b1;
        end

        // Head-at-entry-0 FIFO; a pop that empties it leaves the head intact.
        case ({w_push, w_pop})
            2'b10: begin
                if (r_count == 2'd0) w_ent0_nxt = w_push_data;
                else                 w_ent1_nxt = w_push_data;
                w_count_nxt = r_count + 2'd1;
            end
            2'b01: begin
                if (r_count == 2'd2) w_ent0_nxt = r_ent1;
                w_count_nxt = r_count - 2'd1;
            end
            2'b11: begin
                if (r_count == 2'd1) begin
                    w_ent0_nxt = w_push_data;
                end else begin
                    w_ent0_nxt = r_ent1;
                    w_ent1_nxt = w_push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RESET) begin
            r_phase      <= S_EVEN;
            r_hold       <= 8'h00;
            r_count      <= 2'd0;
            r_flush_pend <= 1'b0;
            r_ent0       <= 16'h0000;
            r_ent1       <= 16'h0000;
        end else begin
            r_phase      <= w_phase_nxt;
            r_hold       <= w_hold_nxt;
            r_count      <= w_count_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            r_ent0       <= w_ent0_nxt;
            r_ent1       <= w_ent1_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/word_assembler.md
WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 The block SHALL have parameter HI_FIRST, default 1: 1 = first byte received goes to bits [15:8]; 0 = first byte goes to bits [7:0].
REQ-002 The block SHALL have parameter PAD_BYTE, default 8'h00: fill value for the missing half of a flushed odd word.
REQ-003 The block SHALL have port CK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port BYTE_IN, input, 8 bits: upstream byte data.
REQ-006 The block SHALL have port BYTE_VALID, input, 1 bit: BYTE_IN holds a valid byte.
REQ-007 The block SHALL have port BYTE_READY, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port FLUSH, input, 1 bit: single-cycle request to close out a half-assembled word.
REQ-009 The block SHALL have port FLUSH_BUSY, output, 1 bit: a flush is pending.
REQ-010 The block SHALL have port WORD_OUT, output, 16 bits: head word of the output buffer, driving the D input of the downstream 16-bit register.
REQ-011 The block SHALL have port WORD_VALID, output, 1 bit: WORD_OUT is valid.
REQ-012 The block SHALL have port WORD_READY, input, 1 bit: downstream takes WORD_OUT this cycle.
REQ-013 The block SHALL have port LOAD, output, 1 bit: clock-enable pulse for the downstream register.
REQ-014 The block SHALL have port ODD, output, 1 bit: a first byte is held awaiting its partner.

Function
REQ-015 A byte transfer SHALL occur on a rising CK when BYTE_VALID and BYTE_READY are both 1; a word transfer SHALL occur when WORD_VALID and WORD_READY are both 1.
REQ-016 The phase state SHALL have two states: EVEN (no byte held) and ODD (one byte held in an 8-bit holding register).
REQ-017 A byte transfer in EVEN SHALL store BYTE_IN in the holding register and move the phase to ODD.
REQ-018 A byte transfer in ODD SHALL push {hold, BYTE_IN} (HI_FIRST=1) or {BYTE_IN, hold} (HI_FIRST=0) into the output buffer and return the phase to EVEN.
REQ-019 The output buffer SHALL be a 2-entry FIFO with a count of 0..2; WORD_OUT SHALL be the head entry and WORD_VALID SHALL equal (count != 0).
REQ-020 BYTE_READY SHALL be 0 when RESET is 1 or FLUSH_BUSY is 1; otherwise it SHALL be 1 when phase=EVEN or count<2.
REQ-021 BYTE_READY SHALL depend only on registered state and RESET, never on WORD_READY.
REQ-022 LOAD SHALL equal WORD_VALID AND WORD_READY, combinationally.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged, pop the old head, and append the new word.
REQ-024 A pop at count 1 with no push SHALL leave count 0 and WORD_OUT holding its last value.
REQ-025 FLUSH in EVEN with no byte transfer in the same cycle SHALL be ignored.
REQ-026 FLUSH in ODD SHALL set flush-pending (FLUSH_BUSY=1).
REQ-027 FLUSH in the same cycle as a byte transfer in ODD SHALL be ignored: the word completes normally.
REQ-028 FLUSH in the same cycle as a byte transfer in EVEN SHALL set flush-pending for the newly held byte.
REQ-029 While flush-pending and count<2 (evaluated before any same-cycle pop), the block SHALL push {hold, PAD_BYTE} (HI_FIRST=1) or {PAD_BYTE, hold} (HI_FIRST=0), clear flush-pending, and return the phase to EVEN.
REQ-030 While flush-pending and count=2, the flush SHALL wait with FLUSH_BUSY=1 until count<2.
REQ-031 Assembly latency SHALL be: the word is visible on WORD_OUT the cycle after the second byte transfer when count was 0.
REQ-032 ODD SHALL be 1 exactly when phase=ODD.

Reset
REQ-033 When RESET=1 at a rising CK, the block SHALL set phase=EVEN, count=0, flush-pending=0, holding register=8'h00, and both FIFO entries=16'h0000, overriding every same-cycle transfer.
REQ-034 After reset and until the next transfer, outputs SHALL be WORD_OUT=16'h0000, WORD_VALID=0, ODD=0, FLUSH_BUSY=0, and LOAD=0.
REQ-035 BYTE_READY SHALL be 1 in the first cycle after RESET deasserts.
REQ-036 A reset asserted while phase=ODD SHALL discard the held byte without emitting it.

Verification
REQ-037 With HI_FIRST=1 and WORD_READY=1: bytes 8'hA5 then 8'h3C -> WORD_OUT=16'hA53C with WORD_VALID=1 one cycle after the second byte, and LOAD=1 in that cycle.
REQ-038 With HI_FIRST=0: bytes 8'h12 then 8'h34 -> WORD_OUT=16'h3412.
REQ-039 With WORD_READY=0, stream bytes 01..06 -> two words 16'h0102 and 16'h0304 buffered, 8'h05 held with ODD=1, BYTE_READY=0; then raise WORD_READY -> words drain in order and 16'h0506 follows.
REQ-040 Byte 8'h7E, then FLUSH with count=2 -> FLUSH_BUSY stays 1 and BYTE_READY=0 until one pop, then 16'h7E00 is pushed and FLUSH_BUSY=0.
REQ-041 FLUSH coincident with the second byte 8'h99 after 8'h11 -> exactly one word 16'h1199 is produced and no pad word follows.
REQ-042 RESET asserted while ODD=1 and count=1 -> the next cycle shows WORD_VALID=0, ODD=0, WORD_OUT=16'h0000, and the subsequent pair 8'hBE, 8'hEF yields 16'hBEEF.
